argmax_frame_source: RTL and testbench



---
 rtl/argmax_pkg.sv | 28 ++
 rtl/frame_sample_ram.sv | 37 +++
 rtl/argmax_frame_source.sv | 144 ++++++++++++++
 tb/tb_argmax_frame_source.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared types and width helpers for the argmax frame source.
// Default parameter values live here so the top and the bench agree on them.
package argmax_pkg;

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      STREAM   = 2'd1,
      WAIT_RES = 2'd2
   } state_e;

   localparam int DEF_BUFFER_LENGTH  = 10;
   localparam int DEF_INDEX_BITS     = 4;
   localparam int DEF_OUT_MAX_BITS   = 4;
   localparam int DEF_I_BITS         = 12;
   localparam int DEF_Q_BITS         = 12;
   localparam int DEF_TIMEOUT_CYCLES = 64;
   localparam int DEF_COUNT_BITS     = 16;

   function automatic int sample_bits(input int ib, input int qb);
      return ib + qb;
   endfunction

   // One extra bit so the counter can hold timeout_cycles-1 for any value.
   function automatic int tmo_bits(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/frame_sample_ram.sv
// Register-array frame buffer: one synchronous write port, one registered read
// port whose output holds whenever re is low.
module frame_sample_ram
   import argmax_pkg::*;
#(
   parameter int DEPTH = DEF_BUFFER_LENGTH,
   parameter int AW    = DEF_INDEX_BITS,
   parameter int DW    = sample_bits(DEF_I_BITS, DEF_Q_BITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Storage is deliberately not reset; every frame rewrites all entries.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/argmax_frame_source.sv
// Captures one frame of I/Q samples, replays it on a valid/ready stream toward
// argmax, then waits (bounded) for the peak result and latches it.
module argmax_frame_source
   import argmax_pkg::*;
#(
   parameter int buffer_length  = DEF_BUFFER_LENGTH,
   parameter int index_bits     = DEF_INDEX_BITS,
   parameter int out_max_bits   = DEF_OUT_MAX_BITS,
   parameter int i_bits         = DEF_I_BITS,
   parameter int q_bits         = DEF_Q_BITS,
   parameter int timeout_cycles = DEF_TIMEOUT_CYCLES,
   parameter int count_bits     = DEF_COUNT_BITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   input  logic [i_bits-1:0]       wr_i,
   input  logic [q_bits-1:0]       wr_q,
   output logic                    wr_ready,
   output logic                    m_axis_tvalid,
   output logic [i_bits-1:0]       xi,
   output logic [q_bits-1:0]       xq,
   output logic                    m_axis_tlast,
   input  logic                    s_axis_tready,
   input  logic                    res_valid,
   input  logic [out_max_bits-1:0] res_max,
   input  logic [index_bits-1:0]   res_index,
   output logic                    peak_valid,
   output logic [out_max_bits-1:0] peak_max,
   output logic [index_bits-1:0]   peak_index,
   output logic [count_bits-1:0]   frame_count,
   output logic                    timeout_err,
   output logic [1:0]              fsm_state
);

   localparam int SW = sample_bits(i_bits, q_bits);
   localparam int TW = tmo_bits(timeout_cycles);

   localparam logic [1:0] S_FILL   = FILL;
   localparam logic [1:0] S_STREAM = STREAM;
   localparam logic [1:0] S_WAIT   = WAIT_RES;

   localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);
   localparam logic [TW-1:0]         TMO_LAST = TW'(timeout_cycles - 1);

   logic [1:0]            state, state_nx;
   logic [index_bits-1:0] wr_ptr, rd_ptr, raddr;
   logic [TW-1:0]         tmo_cnt;
   logic [SW-1:0]         rdata;
   logic                  wr_fire, last_wr, rd_fire, last_rd, tmo_hit, res_take, re;

   // Handshakes: a beat moves on a rising edge where valid and ready are both
   // high; the source never drops valid or changes data until that edge.
   assign wr_fire  = wr_valid & wr_ready & (state == S_FILL) & rst_n;
   assign last_wr  = wr_fire & (wr_ptr == LAST_IDX);
   assign rd_fire  = m_axis_tvalid & s_axis_tready;
   assign last_rd  = rd_fire & m_axis_tlast;
   assign tmo_hit  = (tmo_cnt == TMO_LAST);
   assign res_take = (state == S_WAIT) & res_valid;

   assign m_axis_tvalid = (state == S_STREAM);
   assign m_axis_tlast  = (state == S_STREAM) & (rd_ptr == LAST_IDX);
   assign fsm_state     = state;

   // Prefetch entry 0 on the last write so the first beat is ready immediately.
   assign re    = last_wr | (rd_fire & ~last_rd);
   assign raddr = last_wr ? '0 : rd_ptr + 1'b1;

   always_comb begin
      state_nx = state;
      case (state)
         S_FILL:   if (last_wr) state_nx = S_STREAM;
         S_STREAM: if (last_rd) state_nx = S_WAIT;
         S_WAIT:   if (res_valid || tmo_hit) state_nx = S_FILL;
         default:  state_nx = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_FILL;
         wr_ready <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tmo_cnt  <= '0;
      end else begin
         state    <= state_nx;
         wr_ready <= (state_nx == S_FILL);
         if (last_wr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (last_rd) begin
            rd_ptr  <= '0;
            tmo_cnt <= '0;
         end else if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

   // A result on the expiry cycle wins over the timeout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         peak_valid  <= 1'b0;
         peak_max    <= '0;
         peak_index  <= '0;
         frame_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         peak_valid <= res_take;
         if (res_take) begin
            peak_max    <= res_max;
            peak_index  <= res_index;
            frame_count <= frame_count + 1'b1;
         end else if ((state == S_WAIT) && tmo_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

   frame_sample_ram #(
      .DEPTH (buffer_length),
      .AW    (index_bits),
      .DW    (SW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_fire),
      .waddr (wr_ptr),
      .wdata ({wr_i, wr_q}),
      .re    (re),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign xi = rdata[SW-1:q_bits];
   assign xq = rdata[q_bits-1:0];

endmodule

// File: tb/tb_argmax_frame_source.sv
// Randomized bench for argmax_frame_source against a frame-level reference
// model: expected sample queue plus expected peak/counter/error state.
module tb_argmax_frame_source;

   localparam int L  = 10;
   localparam int T  = 64;
   localparam int W  = 24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [11:0] wr_i, wr_q;
   logic        wr_ready;
   logic        m_axis_tvalid, m_axis_tlast;
   logic [11:0] xi, xq;
   logic        s_axis_tready;
   logic        res_valid;
   logic [3:0]  res_max, res_index;
   logic        peak_valid;
   logic [3:0]  peak_max, peak_index;
   logic [15:0] frame_count;
   logic        timeout_err;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   logic [3:0]   m_max, m_idx;
   logic [15:0]  m_count;
   logic         m_err;

   // clock / reset
   always #5 clk = ~clk;

   argmax_frame_source dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_valid      (wr_valid),
      .wr_i          (wr_i),
      .wr_q          (wr_q),
      .wr_ready      (wr_ready),
      .m_axis_tvalid (m_axis_tvalid),
      .xi            (xi),
      .xq            (xq),
      .m_axis_tlast  (m_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .res_valid     (res_valid),
      .res_max       (res_max),
      .res_index     (res_index),
      .peak_valid    (peak_valid),
      .peak_max      (peak_max),
      .peak_index    (peak_index),
      .frame_count   (frame_count),
      .timeout_err   (timeout_err),
      .fsm_state     (fsm_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_max   = '0;
      m_idx   = '0;
      m_count = '0;
      m_err   = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_wr_ready"},    wr_ready, 0);
      chk({tag, "_tvalid"},      m_axis_tvalid, 0);
      chk({tag, "_tlast"},       m_axis_tlast, 0);
      chk({tag, "_xi"},          xi, 0);
      chk({tag, "_xq"},          xq, 0);
      chk({tag, "_peak_valid"},  peak_valid, 0);
      chk({tag, "_peak_max"},    peak_max, 0);
      chk({tag, "_peak_index"},  peak_index, 0);
      chk({tag, "_frame_count"}, frame_count, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   // driver: one frame of writes; ramp gives (k,-k), otherwise random with gaps
   task automatic fill_frame(input bit ramp);
      int n = 0;
      int cyc = 0;
      logic v;
      logic [11:0] di, dq;
      while (n < L && cyc < 200) begin
         @(negedge clk);
         cyc++;
         chk("fill_wr_ready", wr_ready, 1);
         chk("fill_tvalid", m_axis_tvalid, 0);
         chk("fill_peak_valid", peak_valid, 0);
         v  = ramp ? 1'b1 : ($urandom_range(0, 2) != 0);
         di = ramp ? 12'(n) : 12'($urandom);
         dq = ramp ? 12'(-n) : 12'($urandom);
         res_valid = ($urandom_range(0, 3) == 0);
         res_max   = 4'($urandom);
         res_index = 4'($urandom);
         wr_valid  = v;
         wr_i      = di;
         wr_q      = dq;
         if (v && wr_ready) begin
            exp_q.push_back({di, dq});
            n++;
         end
      end
      if (n < L) chk("fill_budget", 0, 1);
   endtask

   // driver + scoreboard: mode 0 always ready, 1 pattern 1,0,0,1, 2 random
   task automatic stream_frame(input int mode, input int abort_after);
      int cyc = 0;
      int ph = 0;
      int xfers = 0;
      bit stalled = 0;
      logic rdy;
      logic [11:0] hi, hq;
      logic hl;
      logic [W-1:0] e;
      logic [3:0] pat = 4'b1001;
      while (exp_q.size() > 0 && cyc < 200 && xfers != abort_after) begin
         @(negedge clk);
         cyc++;
         chk("s_tvalid", m_axis_tvalid, 1);
         chk("s_peak_valid", peak_valid, 0);
         chk("s_frame_count", frame_count, m_count);
         if (stalled) begin
            chk("hold_xi", xi, hi);
            chk("hold_xq", xq, hq);
            chk("hold_tlast", m_axis_tlast, hl);
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[3 - (ph % 4)];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         ph++;
         s_axis_tready = rdy;
         wr_valid  = 1'($urandom_range(0, 1));
         wr_i      = 12'($urandom);
         wr_q      = 12'($urandom);
         res_valid = ($urandom_range(0, 3) == 0);
         if (m_axis_tvalid && rdy) begin
            e = exp_q.pop_front();
            chk("s_xi", xi, e[23:12]);
            chk("s_xq", xq, e[11:0]);
            chk("s_tlast", m_axis_tlast, (exp_q.size() == 0));
            stalled = 0;
            xfers++;
         end else begin
            stalled = m_axis_tvalid;
            hi = xi;
            hq = xq;
            hl = m_axis_tlast;
         end
      end
      if (exp_q.size() > 0 && xfers != abort_after) chk("stream_budget", 0, 1);
   endtask

   // driver + model for the result phase; d >= T means no result is sent
   task automatic wait_result(input int d, input int rm_i, input int ri_i);
      logic [3:0] rm, ri;
      int lim;
      rm  = (rm_i < 0) ? 4'($urandom_range(0, 15)) : 4'(rm_i);
      ri  = (ri_i < 0) ? 4'($urandom_range(0, L - 1)) : 4'(ri_i);
      lim = (d < T) ? d : T - 1;
      for (int i = 0; i <= lim; i++) begin
         @(negedge clk);
         chk("w_tvalid", m_axis_tvalid, 0);
         chk("w_tlast", m_axis_tlast, 0);
         chk("w_wr_ready", wr_ready, 0);
         chk("w_peak_valid", peak_valid, 0);
         chk("w_timeout_err", timeout_err, m_err);
         s_axis_tready = 1'($urandom_range(0, 1));
         wr_valid  = 1'b0;
         res_valid = (i == d);
         res_max   = rm;
         res_index = ri;
      end
      @(negedge clk);
      res_valid = 1'b0;
      if (d < T) begin
         m_max = rm;
         m_idx = ri;
         m_count++;
         chk("r_peak_valid", peak_valid, 1);
      end else begin
         m_err = 1'b1;
         chk("r_peak_valid", peak_valid, 0);
      end
      chk("r_peak_max", peak_max, m_max);
      chk("r_peak_index", peak_index, m_idx);
      chk("r_frame_count", frame_count, m_count);
      chk("r_timeout_err", timeout_err, m_err);
      chk("r_wr_ready", wr_ready, 1);
      @(negedge clk);
      chk("r_pulse_end", peak_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_valid = 1'b0;
      wr_i = '0;
      wr_q = '0;
      s_axis_tready = 1'b0;
      res_valid = 1'b0;
      res_max = '0;
      res_index = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;

      // basic ramp frame and known result
      fill_frame(1'b1);
      stream_frame(0, -1);
      wait_result(3, 7, 9);

      // backpressure 1,0,0,1 with immediate result
      fill_frame(1'b0);
      stream_frame(1, -1);
      wait_result(0, -1, -1);

      // result on the exact expiry cycle
      fill_frame(1'b0);
      stream_frame(2, -1);
      wait_result(T - 1, -1, -1);

      // no result at all
      fill_frame(1'b0);
      stream_frame(2, -1);
      wait_result(T + 10, -1, -1);

      for (int f = 0; f < 4; f++) begin
         fill_frame(1'b0);
         stream_frame(2, -1);
         wait_result($urandom_range(0, 20), -1, -1);
      end

      // reset after 4 transfers, then a clean frame from entry 0
      fill_frame(1'b0);
      stream_frame(0, 4);
      @(negedge clk);
      rst_n = 1'b0;
      s_axis_tready = 1'b1;
      wr_valid = 1'b0;
      res_valid = 1'b0;
      @(negedge clk);
      model_reset();
      check_reset_vals("midrst");
      rst_n = 1'b1;
      fill_frame(1'b1);
      stream_frame(1, -1);
      wait_result(5, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
